// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Brings an asynchronous level into the clk domain through a flop chain, then
// accepts a level change only after DEBOUNCE_CYCLES consecutive en-qualified
// samples that differ from the current output. A candidate change that bounces
// back before it qualifies is counted in a saturating glitch counter.
//
// Parameters
//   SYNC_STAGES     synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES consecutive differing strobes needed to accept a change (>= 1)
//   RESET_LEVEL     reset value of o and of every synchronizer flop
//
// Ports
//   clk         single clock
//   rst         synchronous, active-high reset
//   i           raw level, asynchronous to clk
//   en          sampling strobe; only en=1 cycles advance the debounce logic
//   clr_glitch  one-cycle pulse clearing glitch_cnt (wins over an increment)
//   o           debounced level, registered
//   busy        high while a candidate transition is being qualified
//   glitch_cnt  saturating count of aborted transitions
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i,
  input  logic       en,
  input  logic       clr_glitch,
  output logic       o,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  // One bit wider than the counter so cnt+1 can be compared without overflow.
  localparam logic [CNT_W:0] CNT_DONE = (CNT_W + 1)'(DEBOUNCE_CYCLES);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         cnt_inc;
  logic                   o_q, o_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   glitch_evt;

  // Synchronizer runs every clock, independent of en.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  // Next-state logic.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_d        = o_q;
    glitch_evt = 1'b0;

    if (en) begin
      unique case (state_q)
        STABLE: begin
          if (s != o_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // A single differing sample is already enough.
              o_d = s;
            end else begin
              state_d = CHECK;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (s != o_q) begin
            if (cnt_inc == CNT_DONE) begin
              o_d     = s;
              cnt_d   = '0;
              state_d = STABLE;
            end else begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end
          end else begin
            // Input returned to the accepted level before qualifying.
            state_d    = STABLE;
            cnt_d      = '0;
            glitch_evt = 1'b1;
          end
        end
      endcase
    end
  end

  // Clear has priority over a coincident glitch; the count sticks at 255.
  always_comb begin
    glitch_d = glitch_q;
    if (clr_glitch) begin
      glitch_d = '0;
    end else if (glitch_evt && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      o_q      <= RESET_LEVEL;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      glitch_q <= glitch_d;
    end
  end

  assign o          = o_q;
  assign busy       = (state_q == CHECK);
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Drives two debounce_sync builds from the same stimulus: DEBOUNCE_CYCLES=4 and
// DEBOUNCE_CYCLES=1 (SYNC_STAGES=2, RESET_LEVEL=0 for both). A reference model
// counts consecutive differing strobes per build and pushes the expected
// outputs into a queue on every clock edge; a monitor pops and compares one
// cycle later. Directed scenarios add constant-valued checks on top.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       i;
  logic       en;
  logic       clr_glitch;
  logic       o4, busy4, o1, busy1;
  logic [7:0] g4, g1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut4 (
    .clk(clk), .rst(rst), .i(i), .en(en), .clr_glitch(clr_glitch),
    .o(o4), .busy(busy4), .glitch_cnt(g4)
  );

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .i(i), .en(en), .clr_glitch(clr_glitch),
    .o(o1), .busy(busy1), .glitch_cnt(g1)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the synchronizer is a delay line of i samples; debounce is
  // "how many en strobes in a row has the synchronized level disagreed with o".
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       o4;
    logic       busy4;
    logic [7:0] g4;
    logic       o1;
    logic       busy1;
    logic [7:0] g1;
  } exp_t;

  exp_t exp_q[$];
  bit   m_pipe[$];
  bit   m_o[2];
  int   m_run[2];
  int   m_g[2];

  function automatic int dc_of(input int c);
    return (c == 0) ? 4 : 1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   s_old;
    bit   glitch;
    if (rst) begin
      m_pipe.delete();
      m_pipe.push_back(1'b0);
      m_pipe.push_back(1'b0);
      for (int c = 0; c < 2; c++) begin
        m_o[c]   = 1'b0;
        m_run[c] = 0;
        m_g[c]   = 0;
      end
    end else begin
      s_old = m_pipe[1];
      for (int c = 0; c < 2; c++) begin
        glitch = 1'b0;
        if (en) begin
          if (s_old != m_o[c]) begin
            m_run[c]++;
            if (m_run[c] == dc_of(c)) begin
              m_o[c]   = s_old;
              m_run[c] = 0;
            end
          end else begin
            if (m_run[c] > 0) glitch = 1'b1;
            m_run[c] = 0;
          end
        end
        if (clr_glitch)                 m_g[c] = 0;
        else if (glitch && m_g[c] < 255) m_g[c] = m_g[c] + 1;
      end
      m_pipe.push_front(i);
      void'(m_pipe.pop_back());
    end
    e.o4    = m_o[0];
    e.busy4 = (m_run[0] > 0);
    e.g4    = 8'(m_g[0]);
    e.o1    = m_o[1];
    e.busy1 = (m_run[1] > 0);
    e.g1    = 8'(m_g[1]);
    exp_q.push_back(e);
  end

  // Monitor: sample 1 time unit after the edge, pop the expectation for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("sb_queue_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_o_dc4",    o4,    e.o4);
        check("sb_busy_dc4", busy4, e.busy4);
        check("sb_glit_dc4", g4,    e.g4);
        check("sb_o_dc1",    o1,    e.o1);
        check("sb_busy_dc1", busy1, e.busy1);
        check("sb_glit_dc1", g1,    e.g1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers; inputs change on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean step to val from the opposite settled level, en=1 throughout.
  task automatic step_test(input bit val);
    i = val;
    cyc(2);
    check("step_busy_pre", busy4, 0);
    check("step_o_pre",    o4,    !val);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("step_busy_qual", busy4, 1);
      check("step_o_qual",    o4,    !val);
    end
    cyc(1);
    check("step_o_done",    o4,    val);
    check("step_busy_done", busy4, 0);
  endtask

  // Two-cycle pulse on i from a settled 0; o must stay 0 and busy must pulse.
  task automatic bounce();
    bit seen_busy;
    seen_busy = 1'b0;
    i = 1'b1;
    cyc(2);
    i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      if (busy4) seen_busy = 1'b1;
      check("bounce_o", o4, 0);
    end
    check("bounce_busy_seen", seen_busy, 1);
    check("bounce_idle", busy4, 0);
  endtask

  initial begin
    rst = 1'b1; i = 1'b1; en = 1'b1; clr_glitch = 1'b0;

    // Reset held two cycles with i=1.
    cyc(2);
    check("rst_o",    o4,    0);
    check("rst_busy", busy4, 0);
    check("rst_glit", g4,    0);
    rst = 1'b0;
    cyc(5);
    check("post_rst_o_early", o4, 0);
    cyc(1);
    check("post_rst_o_6th",   o4, 1);

    // Clean steps both ways.
    step_test(1'b0);
    step_test(1'b1);
    step_test(1'b0);

    // Reset while qualifying (cnt=2), then full re-qualification.
    i = 1'b1;
    cyc(4);
    check("midrst_busy_before", busy4, 1);
    rst = 1'b1;
    cyc(1);
    check("midrst_o",    o4,    0);
    check("midrst_busy", busy4, 0);
    check("midrst_glit", g4,    0);
    rst = 1'b0;
    cyc(5);
    check("midrst_requal_early", o4, 0);
    cyc(1);
    check("midrst_requal_done",  o4, 1);
    check("midrst_glit_after",   g4, 0);

    // en strobed once every 4 clocks, i goes 0 then back to 1 held.
    step_test(1'b0);
    en = 1'b0;
    i  = 1'b1;
    cyc(2);
    for (int k = 1; k <= 4; k++) begin
      en = 1'b1;
      cyc(1);
      check("en_gate_strobe", o4, (k == 4) ? 1 : 0);
      en = 1'b0;
      cyc(3);
      check("en_gate_hold",   o4, (k == 4) ? 1 : 0);
    end
    en = 1'b1;

    // Bounces.
    step_test(1'b0);
    bounce();
    check("glit_after_1", g4, 1);
    bounce();
    bounce();
    check("glit_after_3", g4, 3);

    // Saturation.
    for (int k = 0; k < 300; k++) bounce();
    check("glit_saturated", g4, 255);

    // Clear coinciding with a bounce abort (abort happens on the 5th edge).
    i = 1'b1;
    cyc(2);
    i = 1'b0;
    cyc(2);
    clr_glitch = 1'b1;
    cyc(1);
    clr_glitch = 1'b0;
    check("clr_wins", g4, 0);
    cyc(3);

    // Randomized phase, checked by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      i = 1'($urandom_range(0, 1));
      for (int h = $urandom_range(1, 9); h > 0; h--) begin
        en         = ($urandom_range(0, 3) != 0);
        clr_glitch = ($urandom_range(0, 40) == 0);
        rst        = ($urandom_range(0, 300) == 0);
        cyc(1);
      end
    end
    rst = 1'b0; en = 1'b1; clr_glitch = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have the parameter SYNC_STAGES, default 2, giving the synchronizer flop count; legal values are 2 or more.
REQ-002 The block SHALL have the parameter DEBOUNCE_CYCLES, default 1000, giving the count of consecutive en-qualified differing samples needed to accept a level change; legal values are 1 or more.
REQ-003 The block SHALL have the parameter RESET_LEVEL, default 0, giving the reset value of o and of every synchronizer flop.
REQ-004 The block SHALL size its internal counter as $clog2(DEBOUNCE_CYCLES+1) bits, with a minimum of 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high; the block uses one clock only.
REQ-007 The block SHALL have port i, input, 1 bit: raw level, asynchronous to clk.
REQ-008 The block SHALL have port en, input, 1 bit: sampling strobe; only cycles with en=1 advance the debounce logic.
REQ-009 The block SHALL have port clr_glitch, input, 1 bit: a one-cycle pulse that clears glitch_cnt.
REQ-010 The block SHALL have port o, output, 1 bit: the debounced level, registered; it drives a downstream edgedet.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a candidate transition is being qualified.
REQ-012 The block SHALL have port glitch_cnt, output, 8 bits: saturating count of aborted transitions.

Function
REQ-013 The synchronizer SHALL shift i through SYNC_STAGES flops every clk, independent of en; its last stage is s.
REQ-014 The FSM SHALL have exactly two states, STABLE and CHECK, and busy SHALL equal (state==CHECK).
REQ-015 In STABLE with en=1 and s!=o, if DEBOUNCE_CYCLES>1 the FSM SHALL go to CHECK with cnt=1; if DEBOUNCE_CYCLES==1 it SHALL load o<=s and stay in STABLE.
REQ-016 In CHECK with en=1 and s!=o, the block SHALL set cnt<=cnt+1; when cnt+1==DEBOUNCE_CYCLES it SHALL load o<=s, clear cnt to 0 and go to STABLE in the same edge.
REQ-017 In CHECK with en=1 and s==o (a bounce back), the block SHALL go to STABLE, set cnt<=0, leave o unchanged and increment glitch_cnt.
REQ-018 With en=0, state, cnt and o SHALL hold; the synchronizer still runs.
REQ-019 glitch_cnt SHALL saturate at 255 and never wrap.
REQ-020 clr_glitch=1 SHALL set glitch_cnt<=0, and clear SHALL win over a simultaneous increment.
REQ-021 Latency with en=1 continuously: o SHALL reflect a clean step on i at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising clk edge after i changes (setup met).
REQ-022 o SHALL change only on an edge where the DEBOUNCE_CYCLES-th consecutive differing sample is taken; o SHALL never toggle more than once per DEBOUNCE_CYCLES en-strobes.
REQ-023 o and busy SHALL be flop outputs or a decode of the state flop only, with no combinational path from i.

Reset
REQ-024 On rst=1 at a clk edge, the block SHALL set all synchronizer flops to RESET_LEVEL, o=RESET_LEVEL, state=STABLE, cnt=0 and glitch_cnt=0, regardless of en, i or clr_glitch.
REQ-025 A reset asserted during CHECK SHALL abort qualification and SHALL NOT count as a glitch; busy SHALL be 0 after the reset edge.
REQ-026 After reset is released, a level on i that differs from RESET_LEVEL SHALL be qualified normally per REQ-015 and REQ-016.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0 unless noted)
REQ-027 The bench SHALL cover this reset case: rst=1 for 2 cycles with i=1 -> o=0, busy=0, glitch_cnt=0; after release with i=1 and en=1, o=1 on the 6th edge.
REQ-028 The bench SHALL cover this clean-step case: i 0->1 held, en=1 -> busy high for 3 cycles, then o=1 on the 6th edge after the change; i 1->0 -> o=0 after 6 further edges.
REQ-029 The bench SHALL cover this bounce case: i=1 for exactly 2 cycles, then 0, en=1 -> o stays 0, busy pulses, glitch_cnt=1; three such bounces -> glitch_cnt=3.
REQ-030 The bench SHALL cover this en-gating case: en=1 once every 4 clks, i held 1 -> o rises on the edge of the 4th en strobe after s=1, never earlier.
REQ-031 The bench SHALL cover this reset-mid-operation case: rst=1 while busy=1 (cnt=2) -> next cycle o=0, busy=0, glitch_cnt unchanged, then re-qualification takes the full 4 strobes.
REQ-032 The bench SHALL cover this saturation and clear case: 300 bounces -> glitch_cnt=255; clr_glitch coinciding with a bounce -> glitch_cnt=0; DEBOUNCE_CYCLES=1 build -> o follows s with busy always 0.
